// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage enables/flushes from memory wait states,
// load-use hazards and EX redirects, plus the data-memory handshake FSM and stall counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic [2:0]        ex_mem_read,
  input  logic              ex_wb_en,
  input  logic              ex_redirect,
  input  logic [2:0]        me_mem_read,
  input  logic [1:0]        me_mem_write,
  input  logic              dmem_ready,
  output logic              dmem_req,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_me_en,
  output logic              me_wb_flush,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  mem_stall_cnt,
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WC_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TMO = WC_W'(MEM_TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state_q;
  logic [WC_W-1:0] wait_cnt_q;

  logic me_acc;
  logic mem_stall;
  logic lu;
  logic redirect_act;
  logic lu_act;

  assign me_acc    = (me_mem_read != 3'd0) || (me_mem_write != 2'd0);
  assign mem_stall = me_acc && !dmem_ready;
  assign lu        = (ex_mem_read != 3'd0) && ex_wb_en && (ex_rd_addr != '0) &&
                     ((id_rs1_used && (ex_rd_addr == id_rs1_addr)) ||
                      (id_rs2_used && (ex_rd_addr == id_rs2_addr)));

  // A memory freeze masks everything; a redirect squashes the load-use bubble.
  assign redirect_act = !rst && !mem_stall && ex_redirect;
  assign lu_act       = !rst && !mem_stall && !ex_redirect && lu;

  always_comb begin
    dmem_req    = 1'b0;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_me_en    = 1'b1;
    me_wb_flush = 1'b0;
    if (!rst) begin
      dmem_req = me_acc;
      if (mem_stall) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_me_en    = 1'b0;
        me_wb_flush = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Timeout flag is set on the same edge the wait counter lands on MEM_TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_stall) begin
            state_q    <= WAIT;
            wait_cnt_q <= '0;
            if (TMO == '0) mem_timeout <= 1'b1;
          end
        end
        WAIT: begin
          if (!mem_stall) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else begin
            if (wait_cnt_q != TMO) wait_cnt_q <= wait_cnt_q + WC_W'(1);
            if ((wait_cnt_q + WC_W'(1) == TMO) || (wait_cnt_q == TMO)) mem_timeout <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_stall_cnt <= '0;
      lu_stall_cnt  <= '0;
      flush_cnt     <= '0;
    end else begin
      if (mem_stall && (mem_stall_cnt != '1)) mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
      if (lu_act && (lu_stall_cnt != '1))     lu_stall_cnt  <= lu_stall_cnt + CNT_W'(1);
      if (redirect_act && (flush_cnt != '1))  flush_cnt     <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, memory waits, redirect priority,
// timeout and reset behaviour with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;
  // Control vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_me_en, me_wb_flush
  localparam logic [6:0] C_NORM  = 7'b1101010;
  localparam logic [6:0] C_STALL = 7'b0000001;
  localparam logic [6:0] C_REDIR = 7'b1111110;
  localparam logic [6:0] C_LU    = 7'b0001110;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic             id_rs1_used, id_rs2_used, ex_wb_en, ex_redirect;
  logic [2:0]       ex_mem_read, me_mem_read;
  logic [1:0]       me_mem_write;
  logic             dmem_ready, dmem_req;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_me_en, me_wb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] mem_stall_cnt, lu_stall_cnt, flush_cnt;
  logic [6:0]       ctrl;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read), .ex_wb_en(ex_wb_en),
    .ex_redirect(ex_redirect),
    .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_me_en(ex_me_en),
    .me_wb_flush(me_wb_flush), .mem_timeout(mem_timeout),
    .mem_stall_cnt(mem_stall_cnt), .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_me_en, me_wb_flush};

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_wb_en = 1'b0; ex_redirect = 1'b0;
    ex_mem_read = '0; me_mem_read = '0; me_mem_write = '0; dmem_ready = 1'b0;
  endtask

  task automatic drive_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic used1,
                          input logic [4:0] rs2, input logic used2, input logic wb);
    ex_mem_read = 3'b010; ex_wb_en = wb; ex_rd_addr = rd;
    id_rs1_addr = rs1; id_rs1_used = used1;
    id_rs2_addr = rs2; id_rs2_used = used2;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    me_mem_read = 3'b010;
    tick();
    tick();
    #1;
    check("rst_dmem_req", 32'(dmem_req), 0);
    check("rst_ctrl", 32'(ctrl), 32'(C_NORM));
    check("rst_state", 32'(dut.state_q), 0);
    check("rst_mem_stall_cnt", mem_stall_cnt, 0);
    check("rst_lu_cnt", lu_stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    rst = 1'b0;
    clear_inputs();
    tick();

    // Load-use on rs1: one bubble, cleared once the load moves on
    drive_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
    #1 check("lu_rs1_ctrl", 32'(ctrl), 32'(C_LU));
    tick();
    clear_inputs();
    #1 check("lu_rs1_cnt", lu_stall_cnt, 1);
    check("lu_rs1_after_ctrl", 32'(ctrl), 32'(C_NORM));

    // No-hazard patterns and an rs2 hazard
    drive_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
    #1 check("lu_x0_ctrl", 32'(ctrl), 32'(C_NORM));
    tick();
    drive_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b1);
    #1 check("lu_rs2_unused_ctrl", 32'(ctrl), 32'(C_NORM));
    check("lu_nohaz_cnt", lu_stall_cnt, 1);
    tick();
    drive_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1);
    #1 check("lu_rs2_ctrl", 32'(ctrl), 32'(C_LU));
    tick();
    drive_lu(5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
    #1 check("lu_nowb_ctrl", 32'(ctrl), 32'(C_NORM));
    check("lu_rs2_cnt", lu_stall_cnt, 2);
    tick();
    clear_inputs();

    // Memory wait: store with 3 not-ready cycles
    me_mem_write = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      #1 check("memw_ctrl", 32'(ctrl), 32'(C_STALL));
      check("memw_req", 32'(dmem_req), 1);
      check("memw_state", 32'(dut.state_q), (i >= 2) ? 1 : 0);
      tick();
    end
    dmem_ready = 1'b1;
    #1 check("memw_done_ctrl", 32'(ctrl), 32'(C_NORM));
    check("memw_done_req", 32'(dmem_req), 1);
    tick();
    clear_inputs();
    #1 check("memw_stall_cnt", mem_stall_cnt, 3);
    check("memw_idle", 32'(dut.state_q), 0);
    check("memw_req_off", 32'(dmem_req), 0);

    // Stall together with redirect: freeze first, flush once afterwards
    me_mem_read = 3'b010;
    ex_redirect = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      #1 check("stredir_ctrl", 32'(ctrl), 32'(C_STALL));
      tick();
    end
    check("stredir_flush_cnt_wait", flush_cnt, 0);
    dmem_ready = 1'b1;
    #1 check("stredir_release_ctrl", 32'(ctrl), 32'(C_REDIR));
    tick();
    clear_inputs();
    #1 check("stredir_flush_cnt", flush_cnt, 1);
    check("stredir_stall_cnt", mem_stall_cnt, 5);

    // Redirect beats load-use
    drive_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1);
    ex_redirect = 1'b1;
    #1 check("redir_lu_ctrl", 32'(ctrl), 32'(C_REDIR));
    tick();
    clear_inputs();
    #1 check("redir_lu_cnt", lu_stall_cnt, 2);
    check("redir_flush_cnt", flush_cnt, 2);

    // Timeout: 6 not-ready cycles with MEM_TIMEOUT=4
    me_mem_read = 3'b001;
    for (int i = 1; i <= 6; i++) begin
      #1 check("tmo_ctrl", 32'(ctrl), 32'(C_STALL));
      check("tmo_flag", 32'(mem_timeout), (i == 6) ? 1 : 0);
      tick();
    end
    dmem_ready = 1'b1;
    #1 check("tmo_release_ctrl", 32'(ctrl), 32'(C_NORM));
    check("tmo_release_flag", 32'(mem_timeout), 1);
    tick();
    clear_inputs();
    #1 check("tmo_sticky", 32'(mem_timeout), 1);
    check("tmo_stall_cnt", mem_stall_cnt, 11);

    // Reset asserted mid-WAIT
    me_mem_read = 3'b100;
    tick();
    tick();
    check("midrst_wait", 32'(dut.state_q), 1);
    rst = 1'b1;
    #1 check("midrst_req", 32'(dmem_req), 0);
    check("midrst_ctrl", 32'(ctrl), 32'(C_NORM));
    tick();
    #1 check("midrst_state", 32'(dut.state_q), 0);
    check("midrst_stall_cnt", mem_stall_cnt, 0);
    check("midrst_lu_cnt", lu_stall_cnt, 0);
    check("midrst_flush_cnt", flush_cnt, 0);
    check("midrst_timeout", 32'(mem_timeout), 0);
    rst = 1'b0;
    clear_inputs();
    tick();
    #1 check("post_rst_stall_cnt", mem_stall_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
